mc_datapath: RTL and testbench
==============================

# mc_datapath

Parametrised multicycle MIPS-subset core: datapath plus integrated control FSM sharing one ALU and one unified instruction/data memory port with a request/ready handshake. Next generation of the single-cycle datapath; it replaces separate instruction/data ports and combinational control with a sequenced, stallable engine. Sits between the top level and a single memory model/arbiter.

## Interface
- NREG, 32: architectural register count (8, 16 or 32); register fields use the low log2(NREG) bits.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, sampled in the cycle mem_ready=1.
- mem_ready  in  1  access completes in this cycle.
- pc  out  32  current program counter.
- retire  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  sticky illegal-instruction flag (only with MC_TRAP_EN, else tied 0).

## Operation
- Instructions: R-type add/sub/and/or/slt, lw, sw, beq, addi, j.
- ALU control codes: 010 add, 110 sub, 000 and, 001 or, 111 slt; zero = (result == 0).
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready: IR<=mem_rdata, pc<=pc+4, go DECODE; else hold.
- DECODE: latch A<=rf[rs], B<=rf[rt], ALUOut<=pc+(signimm<<2); dispatch by opcode: lw/sw->MEMADR, R->EXEC, beq->BRANCH, addi->ADDIEX, j->JUMP, other->FETCH (or TRAP with MC_TRAP_EN).
- MEMADR: ALUOut<=A+signimm; lw->MEMRD, sw->MEMWR.
- MEMRD: mem_req=1, addr=ALUOut; on mem_ready Data<=mem_rdata, go MEMWB. MEMWB: rf[rt]<=Data, retire, ->FETCH.
- MEMWR: mem_req=1, mem_we=1, addr=ALUOut, wdata=B; on mem_ready retire, ->FETCH.
- EXEC: ALUOut<=A op B by funct (32/34/36/37/42); unknown funct treated as illegal. ALUWB: rf[rd]<=ALUOut, retire, ->FETCH.
- BRANCH: if A==B pc<=ALUOut; retire; ->FETCH.
- ADDIEX: ALUOut<=A+signimm. ADDIWB: rf[rt]<=ALUOut, retire, ->FETCH.
- JUMP: pc<={pc[31:28], IR[25:0], 2'b00}; retire; ->FETCH.
- Register 0 reads 0; writes to it are discarded. All arithmetic modulo 2^32; signimm is 16-bit sign extension; slt signed.
- mem_addr[1:0] always driven as issued; misalignment not checked.

## Timing
- Reset: state<=FETCH, pc<=RESET_PC, IR/A/B/ALUOut/Data<=0, all registers<=0, retire=0, trap=0. mem_req=0 while reset high; 1 in first cycle after release.
- Reset mid-access (any state, mem_ready pending) aborts the access; no register/memory write from the aborted instruction.
- Zero-wait cycles (mem_ready=1 throughout): j 3, beq 3, R 4, addi 4, sw 4, lw 5.
- Each cycle with mem_req=1 and mem_ready=0 adds one cycle; mem_addr/mem_we/mem_wdata held stable until mem_ready.
- mem_ready ignored when mem_req=0.
- retire asserts in the final cycle of each instruction, never in two consecutive cycles.
- Register write and read of same register across instructions: written value visible to the next DECODE (no forwarding needed).

## Configuration
- MC_TRAP_EN defined: illegal opcode/funct enters TRAP; trap<=1 (sticky), mem_req=0, pc frozen, no retire, until reset.
- Undefined: illegal encodings retire nothing, cause no state change, return to FETCH; trap tied 0.

## Structure
- Package mc_pkg: state enum, opcode constants (R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010), funct constants, ALU control codes.
- Sub-module mc_ctrl: FSM plus opcode/funct decode producing enables, mux selects and alucontrol; datapath registers, register file and ALU remain in mc_datapath.

## Test plan
- Reset with RESET_PC=0x40: pc=0x40, first mem_addr=0x40, retire=0, trap=0.
- addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> $3=2; slt $4,$2,$1 -> $4=1; 4-cycle spacing between retires.
- sw $1,8($0) then lw $5,8($0), memory model mem_ready low 3 cycles per access -> write data 5 at 0x8, $5=5, address/wdata stable while stalled.
- beq taken with offset -2 at pc=0x10 -> pc=0x0C; not taken -> 0x14; j 0x100 from 0x2000_0000 -> pc=0x2000_0400.
- Write to $0 via add $0,$1,$1 then add $6,$0,$0 -> $6=0.
- Opcode 111111: with MC_TRAP_EN trap=1, mem_req=0 until reset; without, no retire and next fetch at pc+4.

Source files
------------

// File: rtl/mc_pkg.sv
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared types and encodings for the mc_datapath multicycle core
//                (FSM states, opcodes, funct codes, ALU controls, mux selects).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam logic [5:0] c_fn_add = 6'd32;
    localparam logic [5:0] c_fn_sub = 6'd34;
    localparam logic [5:0] c_fn_and = 6'd36;
    localparam logic [5:0] c_fn_or  = 6'd37;
    localparam logic [5:0] c_fn_slt = 6'd42;

    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_slt = 3'b111;

    localparam logic [1:0] c_srcb_b    = 2'd0;
    localparam logic [1:0] c_srcb_four = 2'd1;
    localparam logic [1:0] c_srcb_imm  = 2'd2;
    localparam logic [1:0] c_srcb_sh   = 2'd3;

    localparam logic [1:0] c_pc_alu    = 2'd0;
    localparam logic [1:0] c_pc_aluout = 2'd1;
    localparam logic [1:0] c_pc_jump   = 2'd2;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == c_fn_add) || (f == c_fn_sub) || (f == c_fn_and) ||
               (f == c_fn_or)  || (f == c_fn_slt);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            c_fn_sub: return c_alu_sub;
            c_fn_and: return c_alu_and;
            c_fn_or:  return c_alu_or;
            c_fn_slt: return c_alu_slt;
            default:  return c_alu_add;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
//  Module      : mc_ctrl
//  Description : Control FSM and opcode/funct decode for mc_datapath.
//                Optional feature macro: MC_TRAP_EN (sticky illegal-op trap).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       abwrite,
    output logic       aluoutwrite,
    output logic       datawrite,
    output logic       retire,
    output logic       trap
);

    state_t r_state;
    logic   w_legal;

    always_comb begin
        case (op)
            c_op_rtype:                                  w_legal = funct_legal(funct);
            c_op_lw, c_op_sw, c_op_beq, c_op_addi, c_op_j: w_legal = 1'b1;
            default:                                     w_legal = 1'b0;
        endcase
    end

`ifdef MC_TRAP_EN
    logic r_trap;
    assign trap = r_trap;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
`ifdef MC_TRAP_EN
            r_trap  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_legal) begin
`ifdef MC_TRAP_EN
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
`else
                        r_state <= S_FETCH;
`endif
                    end else begin
                        case (op)
                            c_op_lw, c_op_sw: r_state <= S_MEMADR;
                            c_op_rtype:       r_state <= S_EXEC;
                            c_op_beq:         r_state <= S_BRANCH;
                            c_op_addi:        r_state <= S_ADDIEX;
                            c_op_j:           r_state <= S_JUMP;
                            default:          r_state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: r_state <= (op == c_op_lw) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode; handshake-qualified strobes gate on mem_ready
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        pcen        = 1'b0;
        pcsrc       = c_pc_alu;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = c_srcb_b;
        alucontrol  = c_alu_add;
        abwrite     = 1'b0;
        aluoutwrite = 1'b0;
        datawrite   = 1'b0;
        retire      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = c_srcb_four;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            S_DECODE: begin
                abwrite     = 1'b1;
                alusrcb     = c_srcb_sh;
                aluoutwrite = 1'b1;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca     = 1'b1;
                alusrcb     = c_srcb_imm;
                aluoutwrite = 1'b1;
            end
            S_MEMRD: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                datawrite = mem_ready;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                retire  = mem_ready;
            end
            S_EXEC: begin
                alusrca     = 1'b1;
                alucontrol  = funct_alu(funct);
                aluoutwrite = 1'b1;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = c_alu_sub;
                pcen       = zero;
                pcsrc      = c_pc_aluout;
                retire     = 1'b1;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_JUMP: begin
                pcen   = 1'b1;
                pcsrc  = c_pc_jump;
                retire = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            retire  = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mc_datapath.sv
// ============================================================================
//  Module      : mc_datapath
//  Description : Multicycle MIPS-subset core with one shared ALU and a unified
//                request/ready memory port. Optional macro: MC_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_datapath
    import mc_pkg::*;
#(
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap
);

    localparam int c_rw = $clog2(NREG);

    logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_data;
    logic [31:0] r_rf [NREG];

    logic            w_iord, w_irwrite, w_pcen, w_regwrite, w_regdst, w_memtoreg;
    logic            w_alusrca, w_abwrite, w_aluoutwrite, w_datawrite, w_zero;
    logic [1:0]      w_pcsrc, w_alusrcb;
    logic [2:0]      w_alucontrol;
    logic [31:0]     w_signimm, w_srca, w_srcb, w_alures, w_rd1, w_rd2, w_wd;
    logic [c_rw-1:0] w_rs, w_rt, w_rd, w_wa;

    mc_ctrl u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .op          (r_ir[31:26]),
        .funct       (r_ir[5:0]),
        .zero        (w_zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .iord        (w_iord),
        .irwrite     (w_irwrite),
        .pcen        (w_pcen),
        .pcsrc       (w_pcsrc),
        .regwrite    (w_regwrite),
        .regdst      (w_regdst),
        .memtoreg    (w_memtoreg),
        .alusrca     (w_alusrca),
        .alusrcb     (w_alusrcb),
        .alucontrol  (w_alucontrol),
        .abwrite     (w_abwrite),
        .aluoutwrite (w_aluoutwrite),
        .datawrite   (w_datawrite),
        .retire      (retire),
        .trap        (trap)
    );

    assign w_rs      = r_ir[21 +: c_rw];
    assign w_rt      = r_ir[16 +: c_rw];
    assign w_rd      = r_ir[11 +: c_rw];
    assign w_wa      = w_regdst ? w_rd : w_rt;
    assign w_wd      = w_memtoreg ? r_data : r_aluout;
    assign w_signimm = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_rd1     = (w_rs == '0) ? 32'd0 : r_rf[w_rs];
    assign w_rd2     = (w_rt == '0) ? 32'd0 : r_rf[w_rt];

    assign w_srca = w_alusrca ? r_a : r_pc;
    always_comb begin
        case (w_alusrcb)
            c_srcb_b:    w_srcb = r_b;
            c_srcb_four: w_srcb = 32'd4;
            c_srcb_imm:  w_srcb = w_signimm;
            default:     w_srcb = {w_signimm[29:0], 2'b00};
        endcase
    end

    always_comb begin
        w_alures = w_srca + w_srcb;
        case (w_alucontrol)
            c_alu_sub: w_alures = w_srca - w_srcb;
            c_alu_and: w_alures = w_srca & w_srcb;
            c_alu_or:  w_alures = w_srca | w_srcb;
            c_alu_slt: w_alures = {31'd0, $signed(w_srca) < $signed(w_srcb)};
            default:   ;
        endcase
    end
    assign w_zero = (w_alures == 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_data   <= '0;
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else begin
            if (w_irwrite)     r_ir     <= mem_rdata;
            if (w_aluoutwrite) r_aluout <= w_alures;
            if (w_datawrite)   r_data   <= mem_rdata;
            if (w_abwrite) begin
                r_a <= w_rd1;
                r_b <= w_rd2;
            end
            if (w_pcen) begin
                case (w_pcsrc)
                    c_pc_aluout: r_pc <= r_aluout;
                    c_pc_jump:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                    default:     r_pc <= w_alures;
                endcase
            end
            // register 0 is hardwired; its writes are dropped here
            if (w_regwrite && (w_wa != '0)) r_rf[w_wa] <= w_wd;
        end
    end

    assign mem_addr  = w_iord ? r_aluout : r_pc;
    assign mem_wdata = r_b;
    assign pc        = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_mc_datapath.sv
// ============================================================================
//  Module      : tb_mc_datapath
//  Description : Scoreboard bench for mc_datapath (retire timing, next-pc,
//                store traffic). Honours MC_TRAP_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [31:0] pc;
    logic        retire, trap;

    logic        mem_req2, mem_we2, retire2, trap2;
    logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc2;

    always #5 clk = ~clk;

    mc_datapath #(.NREG(32), .RESET_PC(32'h0000_0040)) u_dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .retire(retire), .trap(trap)
    );

    // second core parked in the upper address segment to exercise j's pc[31:28]
    mc_datapath #(.NREG(8), .RESET_PC(32'h2000_0000)) u_dut_hi (
        .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
        .mem_ready(1'b1), .pc(pc2), .retire(retire2), .trap(trap2)
    );
    assign mem_rdata2 = (mem_addr2 == 32'h2000_0000) ? 32'h0800_0100 : 32'h1000_FFFF;

    typedef struct { int gap; logic [31:0] npc; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

    ret_t        ret_q[$];
    st_t         st_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0, n_err = 0;
    int          stall_n = 0, wcnt = 0, cyc = 0, last_ret = 0, ret_cnt = 0, st_cnt = 0;
    logic        pc_pend = 1'b0;
    logic [31:0] pc_exp, h_addr, h_wdata;
    logic        h_we;
    ret_t        re;
    st_t         se;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction
    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'b000010, t};
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h1000_FFFF;
    endfunction

    task automatic exp_ret(input int gap, input logic [31:0] npc);
        ret_t r;
        r.gap = gap; r.npc = npc;
        ret_q.push_back(r);
    endtask
    task automatic exp_st(input logic [31:0] a, input logic [31:0] d);
        st_t s;
        s.addr = a; s.data = d;
        st_q.push_back(s);
    endtask

    // memory model, then retire/pc monitor once outputs have settled
    always @(negedge clk) begin
        if (reset || !mem_req) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else begin
            if (wcnt == 0) begin
                h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
            end
            if (wcnt >= stall_n) begin
                if (stall_n > 0) begin
                    check_eq("hold_addr", mem_addr, h_addr);
                    check_eq("hold_wdata", {mem_wdata[31:1], mem_we}, {h_wdata[31:1], h_we});
                end
                mem_ready = 1'b1;
                mem_rdata = mem_rd(mem_addr);
                wcnt = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    st_cnt++;
                    check_eq("store_expected", {31'd0, st_q.size() != 0}, 32'd1);
                    if (st_q.size() != 0) begin
                        se = st_q.pop_front();
                        check_eq("store_addr", mem_addr, se.addr);
                        check_eq("store_data", mem_wdata, se.data);
                    end
                end
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end
        #1;
        cyc++;
        if (reset) begin
            last_ret = cyc;
            ret_cnt  = 0;
            pc_pend  = 1'b0;
        end else begin
            if (pc_pend) begin
                check_eq("next_pc", pc, pc_exp);
                pc_pend = 1'b0;
            end
            if (retire) begin
                ret_cnt++;
                if (ret_q.size() != 0) begin
                    re = ret_q.pop_front();
                    check_eq("retire_gap", 32'(cyc - last_ret), 32'(re.gap));
                    pc_exp  = re.npc;
                    pc_pend = 1'b1;
                end
                last_ret = cyc;
            end
        end
    end

    task automatic begin_test(input int stall);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        stall_n = stall;
        st_cnt  = 0;
        mem.delete();
        ret_q.delete();
        st_q.delete();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_ret(input int n);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #2;
            if (ret_cnt >= n) return;
        end
        check_eq("retire_timeout", 32'(ret_cnt), 32'(n));
    endtask

    task automatic end_test(input int n);
        wait_ret(n);
        repeat (2) @(negedge clk);
        #2;
        check_eq("ret_q_drained", 32'(ret_q.size()), 32'd0);
        check_eq("st_q_drained", 32'(st_q.size()), 32'd0);
    endtask

    logic [31:0] prog [17];

    initial begin
        // ---- reset state + ALU program, zero-wait memory ----
        begin_test(0);
        @(negedge clk); #2;
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_retire", {31'd0, retire}, 32'd0);
        check_eq("rst_trap", {31'd0, trap}, 32'd0);
        prog[0]  = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
        prog[1]  = enc_i(6'b001000, 5'd0, 5'd2, 16'hFFFD);
        prog[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'd32);
        prog[3]  = enc_r(5'd2, 5'd1, 5'd4, 6'd42);
        prog[4]  = enc_r(5'd1, 5'd2, 5'd7, 6'd34);
        prog[5]  = enc_r(5'd1, 5'd2, 5'd8, 6'd36);
        prog[6]  = enc_r(5'd1, 5'd2, 5'd9, 6'd37);
        prog[7]  = enc_r(5'd1, 5'd2, 5'd10, 6'd42);
        prog[8]  = enc_r(5'd1, 5'd1, 5'd0, 6'd32);
        prog[9]  = enc_r(5'd0, 5'd0, 5'd6, 6'd32);
        prog[10] = enc_i(6'b101011, 5'd0, 5'd3, 16'h0100);
        prog[11] = enc_i(6'b101011, 5'd0, 5'd4, 16'h0104);
        prog[12] = enc_i(6'b101011, 5'd0, 5'd7, 16'h0108);
        prog[13] = enc_i(6'b101011, 5'd0, 5'd8, 16'h010C);
        prog[14] = enc_i(6'b101011, 5'd0, 5'd9, 16'h0110);
        prog[15] = enc_i(6'b101011, 5'd0, 5'd10, 16'h0114);
        prog[16] = enc_i(6'b101011, 5'd0, 5'd6, 16'h0118);
        for (int i = 0; i < 17; i++) begin
            mem[32'h40 + 32'(4 * i)] = prog[i];
            exp_ret(4, 32'h44 + 32'(4 * i));
        end
        exp_st(32'h100, 32'd2);
        exp_st(32'h104, 32'd1);
        exp_st(32'h108, 32'd8);
        exp_st(32'h10C, 32'd5);
        exp_st(32'h110, 32'hFFFF_FFFD);
        exp_st(32'h114, 32'd0);
        exp_st(32'h118, 32'd0);
        release_reset();
        @(negedge clk); #2;
        check_eq("reset_pc", pc, 32'h40);
        check_eq("first_mem_addr", mem_addr, 32'h40);
        check_eq("first_mem_req", {31'd0, mem_req}, 32'd1);
        repeat (2) @(negedge clk); #2;
        check_eq("hi_j_retire", {31'd0, retire2}, 32'd1);
        @(negedge clk); #2;
        check_eq("hi_j_target", pc2, 32'h2000_0400);
        end_test(17);

        // ---- sw/lw with 3 wait states per access ----
        begin_test(3);
        mem[32'h40] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
        mem[32'h44] = enc_i(6'b101011, 5'd0, 5'd1, 16'h0008);
        mem[32'h48] = enc_i(6'b100011, 5'd0, 5'd5, 16'h0008);
        mem[32'h4C] = enc_i(6'b101011, 5'd0, 5'd5, 16'h000C);
        exp_ret(7, 32'h44);
        exp_ret(10, 32'h48);
        exp_ret(11, 32'h4C);
        exp_ret(10, 32'h50);
        exp_st(32'h8, 32'd5);
        exp_st(32'hC, 32'd5);
        release_reset();
        end_test(4);

        // ---- beq not-taken / taken and j ----
        begin_test(0);
        mem[32'h40] = enc_i(6'b001000, 5'd0, 5'd1, 16'd1);
        mem[32'h44] = enc_j(26'd4);
        mem[32'h10] = enc_i(6'b000100, 5'd1, 5'd0, 16'hFFFE);
        mem[32'h14] = enc_i(6'b001000, 5'd0, 5'd1, 16'd0);
        mem[32'h18] = enc_j(26'd4);
        exp_ret(4, 32'h44);
        exp_ret(3, 32'h10);
        exp_ret(3, 32'h14);
        exp_ret(4, 32'h18);
        exp_ret(3, 32'h10);
        exp_ret(3, 32'h0C);
        release_reset();
        end_test(6);

        // ---- illegal opcode 111111 ----
        begin_test(0);
        mem[32'h40] = 32'hFC00_0000;
        mem[32'h44] = enc_i(6'b001000, 5'd0, 5'd1, 16'd7);
        mem[32'h48] = enc_i(6'b101011, 5'd0, 5'd1, 16'h0020);
`ifdef MC_TRAP_EN
        release_reset();
        repeat (10) @(negedge clk); #2;
        check_eq("trap_flag", {31'd0, trap}, 32'd1);
        check_eq("trap_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("trap_pc", pc, 32'h44);
        check_eq("trap_retires", 32'(ret_cnt), 32'd0);
`else
        exp_ret(6, 32'h48);
        exp_ret(4, 32'h4C);
        exp_st(32'h20, 32'd7);
        release_reset();
        repeat (3) @(negedge clk); #2;
        check_eq("illegal_next_fetch", mem_addr, 32'h44);
        check_eq("illegal_trap", {31'd0, trap}, 32'd0);
        end_test(2);
`endif

        // ---- reset asserted while a store is stalled ----
        begin_test(3);
        mem[32'h40] = enc_i(6'b001000, 5'd0, 5'd1, 16'd9);
        mem[32'h44] = enc_i(6'b101011, 5'd0, 5'd1, 16'h0030);
        exp_ret(7, 32'h44);
        release_reset();
        wait_ret(1);
        check_eq("abort_trap_clear", {31'd0, trap}, 32'd0);
        repeat (7) @(posedge clk);
        @(negedge clk); #2;
        check_eq("abort_in_store", {mem_addr[31:1], mem_we}, {31'h18, 1'b1});
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(negedge clk); #2;
        check_eq("abort_no_store", 32'(st_cnt), 32'd0);
        check_eq("abort_mem_untouched", {31'd0, mem.exists(32'h30)}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
